// File: rtl/strb_pkg.sv
// Shared constants for the strobe scheduler: default widths and FSM state encodings.
package strb_pkg;

  localparam int unsigned PER_W_DEF = 16;
  localparam int unsigned CNT_W_DEF = 8;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

endpackage

// File: rtl/strb_div_core.sv
// Loadable period counter: counts 0..period-1 while enabled and flags the terminal count.
module strb_div_core
  import strb_pkg::*;
#(
  parameter int unsigned PER_W = PER_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [PER_W-1:0] period,
  output logic             tick
);

  logic [PER_W-1:0] cnt_q, cnt_d;

  // period is never 0 here, so period-1 cannot underflow
  assign tick = en && (cnt_q == (period - PER_W'(1)));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + PER_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/strb_sched.sv
// Runtime-programmable strobe scheduler (FSM, config registers, pulse counter).
// Optional start-phase delay is enabled by defining STRB_SCHED_PHASE_EN.
module strb_sched
  import strb_pkg::*;
#(
  parameter int unsigned PER_W = PER_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PER_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_count,
`ifdef STRB_SCHED_PHASE_EN
  input  logic [PER_W-1:0] cfg_phase,
`endif
  input  logic             start,
  input  logic             stop,
  output logic             strobe,
  output logic             busy,
  output logic             done
);

  logic [1:0]       state_q, state_d;
  logic [PER_W-1:0] period_q, period_in;
  logic [CNT_W-1:0] count_q, pulses_q, pulses_inc;
  logic             strobe_q, done_q;
  logic             cfg_fire, start_go, core_en, tick, fire, last;

  assign cfg_ready = (state_q == StIdle);
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign start_go  = (state_q == StIdle) && start && !stop;
  assign period_in = (cfg_period == '0) ? PER_W'(1) : cfg_period;

`ifdef STRB_SCHED_PHASE_EN
  logic [PER_W-1:0] phase_q, phase_cnt_q;

  // Divider is held at zero until the phase delay has elapsed
  assign core_en = (state_q == StRun) && (phase_cnt_q == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q     <= '0;
      phase_cnt_q <= '0;
    end else begin
      if (cfg_fire) phase_q <= cfg_phase;
      if (start_go) begin
        phase_cnt_q <= cfg_fire ? cfg_phase : phase_q;
      end else if ((state_q == StRun) && (phase_cnt_q != '0)) begin
        phase_cnt_q <= phase_cnt_q - PER_W'(1);
      end
    end
  end
`else
  assign core_en = (state_q == StRun);
`endif

  strb_div_core #(
    .PER_W (PER_W)
  ) u_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (start_go),
    .en     (core_en),
    .period (period_q),
    .tick   (tick)
  );

  assign fire       = tick && !stop;
  assign pulses_inc = (&pulses_q) ? pulses_q : pulses_q + CNT_W'(1);
  assign last       = fire && (count_q != '0) && (pulses_inc == count_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_go) state_d = StRun;
      StRun: begin
        if (stop)      state_d = StIdle;
        else if (last) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      period_q <= PER_W'(1);
      count_q  <= '0;
      pulses_q <= '0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      strobe_q <= fire;
      done_q   <= (state_q == StDone);
      if (cfg_fire) begin
        period_q <= period_in;
        count_q  <= cfg_count;
      end
      if (start_go)  pulses_q <= '0;
      else if (fire) pulses_q <= pulses_inc;
    end
  end

  assign strobe = strobe_q;
  assign busy   = (state_q == StRun);
  assign done   = done_q;

endmodule

// File: tb/tb_strb_sched.sv
// Directed self-checking bench for strb_sched; covers STRB_SCHED_PHASE_EN when defined.
module tb_strb_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [15:0] cfg_period = '0;
  logic [7:0]  cfg_count = '0;
`ifdef STRB_SCHED_PHASE_EN
  logic [15:0] cfg_phase = '0;
`endif
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        cfg_ready, strobe, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  strb_sched #(
    .PER_W (16),
    .CNT_W (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_period (cfg_period),
    .cfg_count  (cfg_count),
`ifdef STRB_SCHED_PHASE_EN
    .cfg_phase  (cfg_phase),
`endif
    .start      (start),
    .stop       (stop),
    .strobe     (strobe),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [15:0] p, input logic [7:0] c);
    cfg_valid  = 1'b1;
    cfg_period = p;
    cfg_count  = c;
    cyc();
    cfg_valid  = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // Bit i of each mask is the expected output value i cycles after the start edge.
  task automatic watch(input string tag, input int n, input int stop_at,
                       input logic [31:0] sm, input logic [31:0] bm,
                       input logic [31:0] dm, input logic [31:0] rm);
    for (int i = 0; i <= n; i++) begin
      if (i > 0) cyc();
      chk($sformatf("%s strobe@%0d", tag, i), 32'(strobe), 32'(sm[i]));
      chk($sformatf("%s busy@%0d", tag, i), 32'(busy), 32'(bm[i]));
      chk($sformatf("%s done@%0d", tag, i), 32'(done), 32'(dm[i]));
      chk($sformatf("%s ready@%0d", tag, i), 32'(cfg_ready), 32'(rm[i]));
      stop = (i == stop_at);
    end
    stop = 1'b0;
  endtask

  initial begin
    cyc();
    cyc();
    chk("rst strobe", 32'(strobe), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst ready", 32'(cfg_ready), 32'd1);
    rst_n = 1'b1;
    cyc();

    // period 4, count 3
    cfg(16'd4, 8'd3);
    go();
    watch("t1", 14, -1, 32'h1110, 32'h0FFF, 32'h2000, 32'h6000);

    // period 1, count 2
    cfg(16'd1, 8'd2);
    go();
    watch("t2", 4, -1, 32'h6, 32'h3, 32'h8, 32'h18);

    // continuous period 5, stop sampled at k+13
    cfg(16'd5, 8'd0);
    go();
    watch("t3", 14, 12, 32'h420, 32'h1FFF, 32'h0, 32'h6000);
    // stop coinciding with terminal count suppresses the strobe
    go();
    watch("t3b", 6, 4, 32'h0, 32'h1F, 32'h0, 32'h60);

    // start+stop together in IDLE
    cfg(16'd2, 8'd2);
    start = 1'b1;
    stop  = 1'b1;
    cyc();
    start = 1'b0;
    stop  = 1'b0;
    chk("t4 ss busy", 32'(busy), 32'd0);
    chk("t4 ss ready", 32'(cfg_ready), 32'd1);
    go();
    cfg_valid  = 1'b1;
    cfg_period = 16'd7;
    cfg_count  = 8'd1;
    watch("t4", 5, -1, 32'h14, 32'hF, 32'h20, 32'h20);
    cfg_valid = 1'b0;
    go();
    watch("t4c", 5, -1, 32'h14, 32'hF, 32'h20, 32'h20);

    // period 0 behaves as 1
    cfg(16'd0, 8'd2);
    go();
    watch("t5", 4, -1, 32'h6, 32'h3, 32'h8, 32'h18);
    // config and start in the same cycle use the new config
    cfg_valid  = 1'b1;
    cfg_period = 16'd3;
    cfg_count  = 8'd1;
    start      = 1'b1;
    cyc();
    cfg_valid  = 1'b0;
    start      = 1'b0;
    watch("t5b", 5, -1, 32'h8, 32'h7, 32'h10, 32'h30);

    // reset mid-burst
    cfg(16'd6, 8'd0);
    go();
    cyc();
    cyc();
    cyc();
    chk("t6 pre busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    cyc();
    chk("t6 strobe", 32'(strobe), 32'd0);
    chk("t6 busy", 32'(busy), 32'd0);
    chk("t6 done", 32'(done), 32'd0);
    chk("t6 ready", 32'(cfg_ready), 32'd1);
    rst_n = 1'b1;
    cyc();
    chk("t6 post done", 32'(done), 32'd0);
    // config back at reset values: period 1, continuous
    go();
    watch("t6b", 3, 2, 32'h6, 32'h7, 32'h0, 32'h8);

`ifdef STRB_SCHED_PHASE_EN
    cfg_phase = 16'd2;
    cfg(16'd4, 8'd1);
    go();
    watch("ph", 8, -1, 32'h40, 32'h3F, 32'h80, 32'h180);
    cfg_phase = 16'd3;
    cfg(16'd4, 8'd1);
    go();
    watch("phs", 5, 2, 32'h0, 32'h7, 32'h0, 32'h38);
    cfg_phase = 16'd0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
